// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard sequencer for the 5-stage MIPS core. It looks at the
//   IF/ID, ID/EX and MEM stages every cycle. It resolves three things:
//   load-use hazards (one bubble), taken branch/jump flushes and multi-cycle
//   data-memory waits. A wait that lasts too long goes to a sticky error trap.
//
//   Handshake: a memory access is pending while Dmem_req_i is high and
//   Dmem_ack_i is low. An ack in the same cycle as the request completes
//   the access with no stall.
//
//   Ports
//     clk_i, rst_i             clock and synchronous active-high reset
//     IDEX_MemRead_i/Rt_i      load in EX and its destination register
//     IFID_Rs_i/Rt_i           source registers of the instruction in ID
//     Branch_taken_i, Jump_i   control transfer resolved in ID
//     Dmem_req_i, Dmem_ack_i   MEM-stage access / completion
//     PC_write_o, IFID_write_o PC and IF/ID load enables
//     IFID_flush_o             clear IF/ID to NOP
//     IDEX_bubble_o            zero control fields entering ID/EX
//     Pipe_stall_o             freeze ID/EX, EX/MEM, MEM/WB
//     err_o                    sticky memory-timeout error
//     state_o                  current FSM state (RUN/LOAD_STALL/MEM_WAIT/ERROR)
//   Optional (macro HAZARD_PERF_CNT_EN)
//     stall_cycles_o           saturating count of cycles with PC_write_o low
//     flush_cnt_o              saturating count of IFID_flush_o pulses
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             Branch_taken_i,
  input  logic             Jump_i,
  input  logic             Dmem_req_i,
  input  logic             Dmem_ack_i,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             Pipe_stall_o,
  output logic             err_o,
  output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_ERROR      = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  logic load_use, mem_wait, ctrl_xfer;

  assign load_use  = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                     ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));
  assign mem_wait  = Dmem_req_i && !Dmem_ack_i;
  assign ctrl_xfer = Branch_taken_i || Jump_i;

  always_comb begin
    PC_write_o    = 1'b1;
    IFID_write_o  = 1'b1;
    IFID_flush_o  = 1'b0;
    IDEX_bubble_o = 1'b0;
    Pipe_stall_o  = 1'b0;
    state_d       = state_q;
    wait_d        = wait_q;
    err_d         = err_q;

    unique case (state_q)
      ST_RUN, ST_LOAD_STALL: begin
        if (mem_wait) begin
          Pipe_stall_o = 1'b1;
          PC_write_o   = 1'b0;
          IFID_write_o = 1'b0;
          state_d      = ST_MEM_WAIT;
          wait_d       = 8'd1;
        end else if (load_use && state_q == ST_RUN) begin
          // The branch/jump is dropped here. It is seen again next cycle,
          // when the same instruction is still in ID.
          PC_write_o    = 1'b0;
          IFID_write_o  = 1'b0;
          IDEX_bubble_o = 1'b1;
          state_d       = ST_LOAD_STALL;
        end else begin
          IFID_flush_o = ctrl_xfer;
          state_d      = ST_RUN;
          wait_d       = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (!Dmem_ack_i) begin
          Pipe_stall_o = 1'b1;
          PC_write_o   = 1'b0;
          IFID_write_o = 1'b0;
          if (wait_q == TIMEOUT_C) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end else if (load_use) begin
          // The pipe was frozen, so the hazard check was held off until the ack.
          PC_write_o    = 1'b0;
          IFID_write_o  = 1'b0;
          IDEX_bubble_o = 1'b1;
          state_d       = ST_LOAD_STALL;
        end else begin
          IFID_flush_o = ctrl_xfer;
          state_d      = ST_RUN;
          wait_d       = 8'd0;
        end
      end
      ST_ERROR: begin
        Pipe_stall_o = 1'b1;
        PC_write_o   = 1'b0;
        IFID_write_o = 1'b0;
        err_d        = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    if (rst_i) begin
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IFID_flush_o  = 1'b0;
      IDEX_bubble_o = 1'b0;
      Pipe_stall_o  = 1'b0;
      state_d       = ST_RUN;
      wait_d        = 8'd0;
      err_d         = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign state_o = rst_i ? 2'd0 : state_q;
  assign err_o   = err_q && !rst_i;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PC_write_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (IFID_flush_o && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. The bench drives directed
// sequences from the test plan, then randomized traffic. Each cycle the
// outputs are compared with a behavioural model written from the hazard
// rules.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 15;
`ifdef HAZARD_PERF_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       IDEX_MemRead_i = 1'b0;
  logic [4:0] IDEX_Rt_i = '0, IFID_Rs_i = '0, IFID_Rt_i = '0;
  logic       Branch_taken_i = 1'b0, Jump_i = 1'b0;
  logic       Dmem_req_i = 1'b0, Dmem_ack_i = 1'b0;
  logic       PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o;
  logic       Pipe_stall_o, err_o;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_o, flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // model state: 0 running, 1 one-cycle load stall, 2 memory wait, 3 trapped
  int m_mode = 0;
  int m_waits = 0;
  bit m_err = 0;
  bit m_known = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_Rt_i(IDEX_Rt_i),
    .IFID_Rs_i(IFID_Rs_i), .IFID_Rt_i(IFID_Rt_i),
    .Branch_taken_i(Branch_taken_i), .Jump_i(Jump_i),
    .Dmem_req_i(Dmem_req_i), .Dmem_ack_i(Dmem_ack_i),
    .PC_write_o(PC_write_o), .IFID_write_o(IFID_write_o),
    .IFID_flush_o(IFID_flush_o), .IDEX_bubble_o(IDEX_bubble_o),
    .Pipe_stall_o(Pipe_stall_o), .err_o(err_o), .state_o(state_o)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles_o(stall_cycles_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check outputs against the model at negedge,
  // then advance the model to what the next edge should produce.
  task automatic step(input logic rst, input logic mr, input logic [4:0] ex_rt,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic br, input logic jp, input logic req, input logic ack);
    bit lu, xfer;
    bit pc, ifw, fl, bub, stl;
    int nmode, nwaits;
    bit nerr;
    rst_i = rst; IDEX_MemRead_i = mr; IDEX_Rt_i = ex_rt;
    IFID_Rs_i = rs; IFID_Rt_i = rt; Branch_taken_i = br; Jump_i = jp;
    Dmem_req_i = req; Dmem_ack_i = ack;
    @(negedge clk);

    lu   = mr && ex_rt != 0 && (ex_rt == rs || ex_rt == rt);
    xfer = br || jp;
    pc = 1; ifw = 1; fl = 0; bub = 0; stl = 0;
    nmode = m_mode; nwaits = m_waits; nerr = m_err;
    if (rst) begin
      pc = 0; ifw = 0; nmode = 0; nwaits = 0; nerr = 0;
    end else if (m_mode == 3) begin
      stl = 1; pc = 0; ifw = 0;
    end else if (m_mode == 2 && !ack) begin
      stl = 1; pc = 0; ifw = 0;
      if (m_waits >= MEM_TIMEOUT) begin nmode = 3; nerr = 1; end
      else nwaits = m_waits + 1;
    end else if (m_mode != 2 && req && !ack) begin
      stl = 1; pc = 0; ifw = 0; nmode = 2; nwaits = 1;
    end else if (lu && m_mode != 1) begin
      pc = 0; ifw = 0; bub = 1; nmode = 1;
    end else begin
      fl = xfer; nmode = 0; nwaits = 0;
    end

    check("outs", {24'd0, PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
                   Pipe_stall_o, err_o, state_o},
          {24'd0, pc, ifw, fl, bub, stl, (!rst && m_err), (rst ? 2'd0 : 2'(m_mode))});
`ifdef HAZARD_PERF_CNT_EN
    if (m_known) begin
      check("stall_cnt", 32'(stall_cycles_o), 32'(m_stalls));
      check("flush_cnt", 32'(flush_cnt_o), 32'(m_flushes));
    end
`endif
    if (rst) begin
      m_stalls = 0; m_flushes = 0; m_known = 1;
    end else begin
      if (!pc && m_stalls < (1 << CNT_W) - 1) m_stalls++;
      if (fl && m_flushes < (1 << CNT_W) - 1) m_flushes++;
    end
    m_mode = nmode; m_waits = nwaits; m_err = nerr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1;
    // reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 2, 0, 1, 0, 1, 0);
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    idle(2);

    // load-use, then the same with $zero as destination
    step(0, 1, 2, 2, 5, 0, 0, 0, 0);
    step(0, 0, 0, 2, 5, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 0, 5, 0, 0, 0, 0);
    idle(1);

    // branch alone, jump alone, then branch with load-use
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 3, 1, 3, 1, 0, 0, 0);
    step(0, 1, 3, 1, 3, 1, 0, 0, 0);
    idle(1);

    // memory wait, acked after 4 stalled cycles; then req+ack together
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // priority: mem wait + load-use + branch, re-evaluated on ack
    step(0, 1, 4, 4, 0, 1, 0, 1, 0);
    step(0, 1, 4, 4, 0, 1, 0, 1, 0);
    step(0, 1, 4, 4, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);

    // timeout: 16 stalled cycles then ERROR, late ack ignored, reset clears
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("timeout_state", 32'(state_o), 32'd3);
    check("timeout_err", 32'(err_o), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_reset_state", 32'(state_o), 32'd0);
    check("post_reset_err", 32'(err_o), 32'd0);
    idle(2);

    // reset in the middle of a memory wait
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
